freq_div_prog: RTL and testbench

Runtime-programmable integer clock divider, the parametrised successor to the fixed `frequency_division` block. It produces a divided square wave `Q` with divisor N in 2..2^DIV_W-1, plus a one-cycle `tick` per output period. The divisor can be reprogrammed on the fly: a new value is applied only at a period boundary, so `Q` never emits a truncated high or low phase. The block sits in the clock-enable generation path and drives strobe-based logic in the same clock domain. It never drives clock pins.

---
 rtl/freq_div_prog.sv | 102 ++++++++++
 tb/tb_freq_div_prog.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/freq_div_prog.sv
// rtl/freq_div_prog.sv - runtime-programmable integer clock-enable divider
module freq_div_prog #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             Q,
    output logic             tick,
    output logic             load_ack,
    output logic [DIV_W-1:0] cnt
);

    localparam logic [DIV_W-1:0] L_N_RST = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] L_TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] L_ONE   = DIV_W'(1);

    // High-phase length ceil(n/2); written as (n>>1)+n[0] so it never overflows DIV_W.
    function automatic logic [DIV_W-1:0] f_high(input logic [DIV_W-1:0] n);
        return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
    endfunction

    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_h;
    logic [DIV_W-1:0] r_p;
    logic             r_pv;
    logic [DIV_W-1:0] r_cnt;
    logic             r_q;
    logic             r_tick;
    logic             r_ack;

    logic             w_last;
    logic             w_wrap;
    logic             w_apply;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_div_clamped;

    assign w_last        = (r_cnt == (r_n - L_ONE));
    assign w_wrap        = en && w_last;
    // A pending divisor is only swapped in at a wrap, so no phase is ever truncated.
    assign w_apply       = w_wrap && r_pv;
    assign w_cnt_inc     = r_cnt + L_ONE;
    assign w_div_clamped = (div < L_TWO) ? L_TWO : div;

    // Phase counter and divided output; reset parks on the last phase so the first enabled edge wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= L_N_RST - L_ONE;
            r_q   <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_q   <= 1'b1;
        end else if (en) begin
            r_cnt <= w_cnt_inc;
            r_q   <= (w_cnt_inc < r_h);
        end
    end

    // Period-start and load-acknowledge strobes, one cycle each.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_ack  <= w_apply;
        end
    end

    // Active divisor and its cached high length, updated only at a wrap with a pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= L_N_RST;
            r_h <= f_high(L_N_RST);
        end else if (w_apply) begin
            r_n <= r_p;
            r_h <= f_high(r_p);
        end
    end

    // Pending load capture; a load on the applying wrap becomes the next pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p  <= '0;
            r_pv <= 1'b0;
        end else if (div_load) begin
            r_p  <= w_div_clamped;
            r_pv <= 1'b1;
        end else if (w_apply) begin
            r_pv <= 1'b0;
        end
    end

    assign Q        = r_q;
    assign tick     = r_tick;
    assign load_ack = r_ack;
    assign cnt      = r_cnt;

endmodule

// File: tb/tb_freq_div_prog.sv
// tb/tb_freq_div_prog.sv - directed self-checking bench for freq_div_prog
module tb_freq_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       div_load;
    logic       Q;
    logic       tick;
    logic       load_ack;
    logic [7:0] cnt;

    int n_cmp;
    int n_bad;

    freq_div_prog #(.DIV_W(8), .DIV_RST(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .Q        (Q),
        .tick     (tick),
        .load_ack (load_ack),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare all outputs on the following falling edge.
    task automatic cyc(input string tag, input logic eq, input logic et,
                       input logic ea, input logic [7:0] ec);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".Q"},        {7'd0, Q},        {7'd0, eq});
        chk({tag, ".tick"},     {7'd0, tick},     {7'd0, et});
        chk({tag, ".load_ack"}, {7'd0, load_ack}, {7'd0, ea});
        chk({tag, ".cnt"},      cnt,              ec);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        div      = 8'd0;
        div_load = 1'b0;

        // Reset default, N=2
        cyc("rst0", 0, 0, 0, 8'd1);
        cyc("rst1", 0, 0, 0, 8'd1);
        rst = 1'b0; en = 1'b1;
        cyc("def1", 1, 1, 0, 8'd0);
        cyc("def2", 0, 0, 0, 8'd1);
        cyc("def3", 1, 1, 0, 8'd0);
        cyc("def4", 0, 0, 0, 8'd1);

        // Odd divisor 5: loaded on a wrap edge, applied at the following wrap
        div = 8'd5; div_load = 1'b1;
        cyc("odd_ldwrap", 1, 1, 0, 8'd0);
        div_load = 1'b0;
        cyc("odd_a", 0, 0, 0, 8'd1);
        cyc("odd_apply", 1, 1, 1, 8'd0);
        cyc("odd_c1", 1, 0, 0, 8'd1);
        cyc("odd_c2", 1, 0, 0, 8'd2);
        cyc("odd_c3", 0, 0, 0, 8'd3);
        cyc("odd_c4", 0, 0, 0, 8'd4);
        cyc("odd_wrap2", 1, 1, 0, 8'd0);

        // Clamp and overwrite: load 0, then 1 two cycles later, one ack, N=2
        div = 8'd0; div_load = 1'b1;
        cyc("clp_ld0", 1, 0, 0, 8'd1);
        div_load = 1'b0;
        cyc("clp_c2", 1, 0, 0, 8'd2);
        div = 8'd1; div_load = 1'b1;
        cyc("clp_ld1", 0, 0, 0, 8'd3);
        div_load = 1'b0;
        cyc("clp_c4", 0, 0, 0, 8'd4);
        cyc("clp_apply", 1, 1, 1, 8'd0);
        cyc("clp_c1", 0, 0, 0, 8'd1);
        cyc("clp_wrap", 1, 1, 0, 8'd0);
        cyc("clp_c1b", 0, 0, 0, 8'd1);
        cyc("clp_wrapb", 1, 1, 0, 8'd0);

        // Go to N=8, then reprogram to 3 while cnt=2
        div = 8'd8; div_load = 1'b1;
        cyc("m8_ld", 0, 0, 0, 8'd1);
        div_load = 1'b0;
        cyc("m8_apply", 1, 1, 1, 8'd0);
        cyc("m8_c1", 1, 0, 0, 8'd1);
        cyc("m8_c2", 1, 0, 0, 8'd2);
        div = 8'd3; div_load = 1'b1;
        cyc("m8_c3", 1, 0, 0, 8'd3);
        div_load = 1'b0;
        cyc("m8_c4", 0, 0, 0, 8'd4);
        cyc("m8_c5", 0, 0, 0, 8'd5);
        cyc("m8_c6", 0, 0, 0, 8'd6);
        cyc("m8_c7", 0, 0, 0, 8'd7);
        cyc("m3_apply", 1, 1, 1, 8'd0);
        cyc("m3_c1", 1, 0, 0, 8'd1);
        cyc("m3_c2", 0, 0, 0, 8'd2);
        cyc("m3_wrap", 1, 1, 0, 8'd0);

        // Enable gating with N=6
        div = 8'd6; div_load = 1'b1;
        cyc("g6_ld", 1, 0, 0, 8'd1);
        div_load = 1'b0;
        cyc("g6_c2", 0, 0, 0, 8'd2);
        cyc("g6_apply", 1, 1, 1, 8'd0);
        cyc("g6_c1", 1, 0, 0, 8'd1);
        cyc("g6_c2b", 1, 0, 0, 8'd2);
        cyc("g6_c3", 0, 0, 0, 8'd3);
        en = 1'b0;
        cyc("g6_hold1", 0, 0, 0, 8'd3);
        cyc("g6_hold2", 0, 0, 0, 8'd3);
        cyc("g6_hold3", 0, 0, 0, 8'd3);
        cyc("g6_hold4", 0, 0, 0, 8'd3);
        en = 1'b1;
        cyc("g6_c4", 0, 0, 0, 8'd4);
        cyc("g6_c5", 0, 0, 0, 8'd5);
        cyc("g6_wrap", 1, 1, 0, 8'd0);

        // Load 4, then load 7 on the wrap that applies 4: 7 stays pending
        div = 8'd4; div_load = 1'b1;
        cyc("w4_ld", 1, 0, 0, 8'd1);
        div_load = 1'b0;
        cyc("w4_c2", 1, 0, 0, 8'd2);
        cyc("w4_c3", 0, 0, 0, 8'd3);
        cyc("w4_c4", 0, 0, 0, 8'd4);
        cyc("w4_c5", 0, 0, 0, 8'd5);
        div = 8'd7; div_load = 1'b1;
        cyc("w4_apply", 1, 1, 1, 8'd0);
        div_load = 1'b0;
        cyc("w4_c1", 1, 0, 0, 8'd1);
        cyc("w4_c2b", 0, 0, 0, 8'd2);

        // Reset with 7 pending: discarded, N back to 2, no ack
        rst = 1'b1;
        cyc("rp_rst0", 0, 0, 0, 8'd1);
        cyc("rp_rst1", 0, 0, 0, 8'd1);
        rst = 1'b0;
        cyc("rp_wrap1", 1, 1, 0, 8'd0);
        cyc("rp_c1", 0, 0, 0, 8'd1);
        cyc("rp_wrap2", 1, 1, 0, 8'd0);
        cyc("rp_c1b", 0, 0, 0, 8'd1);
        cyc("rp_wrap3", 1, 1, 0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
